// File: rtl/ifu_exu_ibuf_pkg.sv
// Shared defines for the IFU/EXU instruction buffer: instruction and PC
// widths, plus the RV32 length encoding in IR[1:0] and a decode helper.
package ifu_exu_ibuf_pkg;

  localparam int         IBUF_XLEN    = 32;
  localparam int         IBUF_PC_SIZE = 32;
  localparam logic [1:0] RV32_OPLEN   = 2'b11;

  // Anything other than 2'b11 in the low two bits is a 16-bit instruction.
  function automatic logic is_rv32(input logic [1:0] op_len);
    return (op_len == RV32_OPLEN);
  endfunction

endpackage

// File: rtl/ifu_exu_ibuf_rv32_dec.sv
// ibuf_rv32_dec: pure instruction-length pre-decode of IR[1:0].
// Kept standalone so the IFU PC-increment logic can reuse the same decode.
module ibuf_rv32_dec
  import ifu_exu_ibuf_pkg::*;
(
  input  logic [1:0] ir_len_i,
  output logic       rv32_o
);

  assign rv32_o = is_rv32(ir_len_i);

endmodule

// File: rtl/ifu_exu_ibuf.sv
// ifu_exu_ibuf: {PC, IR} FIFO decoupling fetch from execute stalls.
// First-word-fall-through head, registered-only IFU ready, flush and reset
// both clear the pointers; reset also clears the storage.
// Optional macro IFU_EXU_IBUF_BYPASS_EN: when the buffer is empty the IFU
// input is forwarded combinationally to the EXU (0-cycle latency).
module ifu_exu_ibuf
  import ifu_exu_ibuf_pkg::*;
#(
  parameter  int DEPTH   = 2,
  parameter  int XLEN    = IBUF_XLEN,
  parameter  int PC_SIZE = IBUF_PC_SIZE,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ibuf_i_ifu_valid,
  output logic               ibuf_o_ifu_ready,
  input  logic [XLEN-1:0]    ibuf_i_ir,
  input  logic [PC_SIZE-1:0] ibuf_i_pc,
  input  logic               ibuf_i_flush,
  output logic               ibuf_o_exu_valid,
  input  logic               ibuf_i_exu_ready,
  output logic [XLEN-1:0]    ibuf_o_ir,
  output logic [PC_SIZE-1:0] ibuf_o_pc,
  output logic               ibuf_o_rv32,
  output logic [CW-1:0]      ibuf_o_count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [XLEN-1:0]    ir_mem_q [DEPTH];
  logic [PC_SIZE-1:0] pc_mem_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic               empty;
  logic               push;
  logic               pop_fifo;
  logic               wr_en;
  logic               bypass_take;
  logic [XLEN-1:0]    head_ir;
  logic [PC_SIZE-1:0] head_pc;

  assign empty   = (count_q == '0);
  assign head_ir = ir_mem_q[rd_ptr_q];
  assign head_pc = pc_mem_q[rd_ptr_q];

  // Ready depends on registered occupancy only, so a full buffer refuses a
  // push even when the EXU pops in the same cycle.
  assign ibuf_o_ifu_ready = (count_q != FULL_CNT);
  assign push             = ibuf_i_ifu_valid & ibuf_o_ifu_ready;

`ifdef IFU_EXU_IBUF_BYPASS_EN
  logic bypass_act;

  // Forward the IFU input only while empty and not flushing.
  assign bypass_act       = empty & ~ibuf_i_flush;
  assign ibuf_o_exu_valid = bypass_act ? ibuf_i_ifu_valid : ~empty;
  assign ibuf_o_ir        = bypass_act ? ibuf_i_ir : head_ir;
  assign ibuf_o_pc        = bypass_act ? ibuf_i_pc : head_pc;
  // A forwarded instruction that the EXU takes is never written.
  assign bypass_take      = bypass_act & ibuf_i_ifu_valid & ibuf_i_exu_ready;
`else
  assign ibuf_o_exu_valid = ~empty;
  assign ibuf_o_ir        = head_ir;
  assign ibuf_o_pc        = head_pc;
  assign bypass_take      = 1'b0;
`endif

  assign pop_fifo     = ~empty & ibuf_i_exu_ready;
  assign wr_en        = push & ~bypass_take;
  assign ibuf_o_count = count_q;

  ibuf_rv32_dec u_rv32_dec (
    .ir_len_i (ibuf_o_ir[1:0]),
    .rv32_o   (ibuf_o_rv32)
  );

  // Pointer/count next state; flush discards any same-cycle push or pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (ibuf_i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en)    wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_fifo) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en && !pop_fifo)      count_d = count_q + 1'b1;
      else if (!wr_en && pop_fifo) count_d = count_q - 1'b1;
    end
  end

  // Pointer/count registers; reset wins over flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage: cleared on reset so empty outputs are never X; written
  // at the tail only, which can never be the live head while not full.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ir_mem_q[i] <= '0;
        pc_mem_q[i] <= '0;
      end
    end else if (wr_en && !ibuf_i_flush) begin
      ir_mem_q[wr_ptr_q] <= ibuf_i_ir;
      pc_mem_q[wr_ptr_q] <= ibuf_i_pc;
    end
  end

endmodule

// File: tb/tb_ifu_exu_ibuf.sv
// Directed bench for ifu_exu_ibuf (DEPTH=2); hand-computed expectations.
module tb_ifu_exu_ibuf;

  logic        clk = 1'b0;
  logic        rst;
  logic        ibuf_i_ifu_valid;
  logic        ibuf_o_ifu_ready;
  logic [31:0] ibuf_i_ir;
  logic [31:0] ibuf_i_pc;
  logic        ibuf_i_flush;
  logic        ibuf_o_exu_valid;
  logic        ibuf_i_exu_ready;
  logic [31:0] ibuf_o_ir;
  logic [31:0] ibuf_o_pc;
  logic        ibuf_o_rv32;
  logic [1:0]  ibuf_o_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ifu_exu_ibuf #(.DEPTH(2), .XLEN(32), .PC_SIZE(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .ibuf_i_ifu_valid (ibuf_i_ifu_valid),
    .ibuf_o_ifu_ready (ibuf_o_ifu_ready),
    .ibuf_i_ir        (ibuf_i_ir),
    .ibuf_i_pc        (ibuf_i_pc),
    .ibuf_i_flush     (ibuf_i_flush),
    .ibuf_o_exu_valid (ibuf_o_exu_valid),
    .ibuf_i_exu_ready (ibuf_i_exu_ready),
    .ibuf_o_ir        (ibuf_o_ir),
    .ibuf_o_pc        (ibuf_o_pc),
    .ibuf_o_rv32      (ibuf_o_rv32),
    .ibuf_o_count     (ibuf_o_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one clock edge, leave 1 time unit of settle after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ibuf_i_ifu_valid = 1'b0; ibuf_i_ir = '0; ibuf_i_pc = '0;
    ibuf_i_flush = 1'b0; ibuf_i_exu_ready = 1'b0;

    // Reset then idle
    tick(); tick();
    rst = 1'b0; #1;
    chk("rst_exu_valid", 32'(ibuf_o_exu_valid), 32'd0);
    chk("rst_ifu_ready", 32'(ibuf_o_ifu_ready), 32'd1);
    chk("rst_count",     32'(ibuf_o_count),     32'd0);
    chk("rst_ir",        ibuf_o_ir,             32'd0);
    chk("rst_pc",        ibuf_o_pc,             32'd0);
    chk("rst_rv32",      32'(ibuf_o_rv32),      32'd0);

    // Single pass
    ibuf_i_ifu_valid = 1'b1; ibuf_i_pc = 32'h80; ibuf_i_ir = 32'h0000_0013;
    ibuf_i_exu_ready = 1'b1;
`ifdef IFU_EXU_IBUF_BYPASS_EN
    #1;
    chk("byp_same_cycle_valid", 32'(ibuf_o_exu_valid), 32'd1);
    chk("byp_same_cycle_pc",    ibuf_o_pc,             32'h80);
    chk("byp_same_cycle_rv32",  32'(ibuf_o_rv32),      32'd1);
    tick();
    ibuf_i_ifu_valid = 1'b0; #1;
    chk("byp_not_written_count", 32'(ibuf_o_count), 32'd0);
`else
    tick();
    ibuf_i_ifu_valid = 1'b0; #1;
    chk("sp_exu_valid", 32'(ibuf_o_exu_valid), 32'd1);
    chk("sp_pc",        ibuf_o_pc,             32'h80);
    chk("sp_ir",        ibuf_o_ir,             32'h0000_0013);
    chk("sp_rv32",      32'(ibuf_o_rv32),      32'd1);
    tick();
    chk("sp_count_after_pop", 32'(ibuf_o_count), 32'd0);
    chk("sp_empty_valid",     32'(ibuf_o_exu_valid), 32'd0);
`endif

    // Fill and stall
    ibuf_i_exu_ready = 1'b0;
    ibuf_i_ifu_valid = 1'b1; ibuf_i_pc = 32'h80; ibuf_i_ir = 32'h0010_0093;
    tick();
    chk("fill1_count", 32'(ibuf_o_count),     32'd1);
    chk("fill1_ready", 32'(ibuf_o_ifu_ready), 32'd1);
    ibuf_i_pc = 32'h84; ibuf_i_ir = 32'h0020_0113;
    tick();
    chk("fill2_count", 32'(ibuf_o_count),     32'd2);
    chk("fill2_ready", 32'(ibuf_o_ifu_ready), 32'd0);
    chk("fill2_head",  ibuf_o_pc,             32'h80);
    ibuf_i_pc = 32'h88; ibuf_i_ir = 32'h0030_0193;
    tick();
    chk("fill3_refused_count", 32'(ibuf_o_count), 32'd2);
    chk("fill3_head_pc",       ibuf_o_pc,         32'h80);
    chk("fill3_head_ir",       ibuf_o_ir,         32'h0010_0093);
    // Full with pop and push same cycle: push still refused
    ibuf_i_exu_ready = 1'b1; #1;
    chk("full_ready_no_comb_path", 32'(ibuf_o_ifu_ready), 32'd0);
    tick();
    ibuf_i_ifu_valid = 1'b0; #1;
    chk("pop1_count", 32'(ibuf_o_count), 32'd1);
    chk("pop1_head",  ibuf_o_pc,         32'h84);
    tick();
    chk("pop2_count", 32'(ibuf_o_count),     32'd0);
    chk("pop2_valid", 32'(ibuf_o_exu_valid), 32'd0);

    // Simultaneous push/pop at count=1 over 10 transfers
    ibuf_i_exu_ready = 1'b0;
    ibuf_i_ifu_valid = 1'b1; ibuf_i_pc = 32'h100; ibuf_i_ir = 32'h0000_0013;
    tick();
    ibuf_i_exu_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      ibuf_i_pc = 32'h100 + 32'(4 * i);
      ibuf_i_ir = 32'h0000_0013 + 32'(i << 7);
      tick();
      chk("pp_count", 32'(ibuf_o_count), 32'd1);
      chk("pp_head",  ibuf_o_pc,         32'h100 + 32'(4 * i));
    end
    ibuf_i_ifu_valid = 1'b0;
    tick();
    chk("pp_drain_count", 32'(ibuf_o_count), 32'd0);

    // Flush mid-stream at count=2 with push asserted
    ibuf_i_exu_ready = 1'b0;
    ibuf_i_ifu_valid = 1'b1; ibuf_i_pc = 32'h80; ibuf_i_ir = 32'h0000_0013;
    tick();
    ibuf_i_pc = 32'h84;
    tick();
    chk("fl_pre_count", 32'(ibuf_o_count), 32'd2);
    ibuf_i_pc = 32'h8C; ibuf_i_flush = 1'b1;
    tick();
    ibuf_i_flush = 1'b0; ibuf_i_ifu_valid = 1'b0; #1;
    chk("fl_count", 32'(ibuf_o_count),     32'd0);
    chk("fl_valid", 32'(ibuf_o_exu_valid), 32'd0);
    chk("fl_ready", 32'(ibuf_o_ifu_ready), 32'd1);
    // Flush at count=1 with an acceptable push: the push is dropped
    ibuf_i_ifu_valid = 1'b1; ibuf_i_pc = 32'h90;
    tick();
    ibuf_i_pc = 32'h94; ibuf_i_flush = 1'b1;
    tick();
    ibuf_i_flush = 1'b0; ibuf_i_pc = 32'hA0;
    tick();
    ibuf_i_ifu_valid = 1'b0; #1;
    chk("fl2_count", 32'(ibuf_o_count), 32'd1);
    chk("fl2_head",  ibuf_o_pc,         32'hA0);
    ibuf_i_exu_ready = 1'b1;
    tick();
    ibuf_i_exu_ready = 1'b0;
    chk("fl2_drain", 32'(ibuf_o_count), 32'd0);

    // Compressed decode
    ibuf_i_ifu_valid = 1'b1; ibuf_i_pc = 32'hB0; ibuf_i_ir = 32'h0000_4501;
    tick();
    chk("c16_rv32", 32'(ibuf_o_rv32), 32'd0);
    chk("c16_ir",   ibuf_o_ir,        32'h0000_4501);
    ibuf_i_exu_ready = 1'b1; ibuf_i_pc = 32'hB2; ibuf_i_ir = 32'h0000_0513;
    tick();
    ibuf_i_ifu_valid = 1'b0; ibuf_i_exu_ready = 1'b0; #1;
    chk("c32_rv32", 32'(ibuf_o_rv32), 32'd1);
    chk("c32_pc",   ibuf_o_pc,        32'hB2);

    // Reset mid-operation, asserted together with flush
    ibuf_i_ifu_valid = 1'b1; ibuf_i_pc = 32'hC0; ibuf_i_ir = 32'h0000_0093;
    tick();
    chk("mid_pre_count", 32'(ibuf_o_count), 32'd2);
    rst = 1'b1; ibuf_i_flush = 1'b1;
    tick();
    rst = 1'b0; ibuf_i_flush = 1'b0; ibuf_i_ifu_valid = 1'b0; #1;
    chk("mid_rst_count", 32'(ibuf_o_count),     32'd0);
    chk("mid_rst_valid", 32'(ibuf_o_exu_valid), 32'd0);
    chk("mid_rst_ready", 32'(ibuf_o_ifu_ready), 32'd1);
    chk("mid_rst_ir",    ibuf_o_ir,             32'd0);
    chk("mid_rst_pc",    ibuf_o_pc,             32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
